// File: rtl/bp_me_pkg.sv
// Shared types for the memory-engine DMA endpoint.
// Holds the responder state encoding and a small width helper.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_ready,
        e_read_wait,
        e_read,
        e_write
    } bp_me_dma_resp_state_e;

    // Counter width that never collapses to zero bits.
    function automatic int lg_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_me_dma_mem_array.sv
// Backing store for the DMA responder.
// One synchronous write port, one combinational read port, no reset.
module bp_me_dma_mem_array #(
    parameter int width_p = 64,
    parameter int els_p   = 1024
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_me_cache_dma_responder.sv
// DRAM stand-in behind a bsg_cache DMA port.
// Serves one packet at a time: a block of read beats or absorbs a block of write beats.
module bp_me_cache_dma_responder
    import bp_me_pkg::*;
#(
    parameter int daddr_width_p         = 28,
    parameter int fill_width_p          = 64,
    parameter int data_width_p          = 64,
    parameter int block_size_in_words_p = 8,
    parameter int mem_els_p             = 1024,
    parameter int read_latency_p        = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [daddr_width_p:0]   dma_pkt_i,
    input  logic                     dma_pkt_v_i,
    output logic                     dma_pkt_ready_and_o,
    output logic [fill_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_ready_and_i,
    input  logic [fill_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o,
    output logic                     busy_o
);

    localparam int beats_lp = block_size_in_words_p * data_width_p / fill_width_p;
    localparam int lg_fill_bytes_lp = $clog2(fill_width_p / 8);
    localparam int idx_width_lp = daddr_width_p - lg_fill_bytes_lp;
    localparam int lg_mem_els_lp = $clog2(mem_els_p);
    localparam int cnt_width_lp = lg_min1(beats_lp);
    localparam int lat_width_lp = lg_min1(read_latency_p + 1);

    localparam logic [cnt_width_lp-1:0] last_beat_lp =
        cnt_width_lp'(beats_lp - 1);
    localparam logic [lat_width_lp-1:0] last_lat_lp =
        lat_width_lp'((read_latency_p > 0) ? read_latency_p - 1 : 0);
    localparam logic [idx_width_lp-1:0] beat_mask_lp =
        idx_width_lp'(beats_lp - 1);

    bp_me_dma_resp_state_e state_r, state_n;

    logic [cnt_width_lp-1:0]  cnt_r;
    logic [lat_width_lp-1:0]  lat_r;
    logic [idx_width_lp-1:0]  base_r;
    logic [idx_width_lp-1:0]  idx_full;
    logic [lg_mem_els_lp-1:0] mem_addr;

    logic                     write_not_read;
    logic [daddr_width_p-1:0] pkt_addr;
    logic                     pkt_fire;
    logic                     rd_fire;
    logic                     wr_fire;
    logic                     last_beat;
    logic                     unused;

    assign write_not_read = dma_pkt_i[daddr_width_p];
    assign pkt_addr       = dma_pkt_i[daddr_width_p-1:0];

    assign pkt_fire  = dma_pkt_v_i & dma_pkt_ready_and_o;
    assign rd_fire   = dma_data_v_o & dma_data_ready_and_i;
    assign wr_fire   = dma_data_v_i & dma_data_ready_and_o;
    assign last_beat = (cnt_r == last_beat_lp);

    // Beat counter overrides the in-block index bits; high bits alias.
    assign idx_full = (base_r & ~beat_mask_lp)
                    | (idx_width_lp'(cnt_r) & beat_mask_lp);
    assign mem_addr = idx_full[lg_mem_els_lp-1:0];

    assign unused = ^{pkt_addr[lg_fill_bytes_lp-1:0],
                      idx_full[idx_width_lp-1:lg_mem_els_lp]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ready: begin
                if (pkt_fire) begin
                    if (write_not_read) begin
                        state_n = e_write;
                    end else if (read_latency_p > 0) begin
                        state_n = e_read_wait;
                    end else begin
                        state_n = e_read;
                    end
                end
            end
            e_read_wait: begin
                if (lat_r == last_lat_lp) begin
                    state_n = e_read;
                end
            end
            e_read: begin
                if (rd_fire && last_beat) begin
                    state_n = e_ready;
                end
            end
            e_write: begin
                if (wr_fire && last_beat) begin
                    state_n = e_ready;
                end
            end
            default: state_n = e_ready;
        endcase
    end

    always_comb begin
        dma_pkt_ready_and_o  = 1'b0;
        dma_data_v_o         = 1'b0;
        dma_data_ready_and_o = 1'b0;
        busy_o               = (state_r != e_ready);
        unique case (state_r)
            e_ready:     dma_pkt_ready_and_o  = 1'b1;
            e_read:      dma_data_v_o         = 1'b1;
            e_write:     dma_data_ready_and_o = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r  <= '0;
            lat_r  <= '0;
            base_r <= '0;
        end else begin
            if (pkt_fire) begin
                base_r <= pkt_addr[daddr_width_p-1:lg_fill_bytes_lp];
                cnt_r  <= '0;
                lat_r  <= '0;
            end else if (rd_fire || wr_fire) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (state_r == e_read_wait) begin
                lat_r <= lat_r + 1'b1;
            end
        end
    end

    bp_me_dma_mem_array #(
        .width_p (fill_width_p),
        .els_p   (mem_els_p)
    ) mem_array (
        .clk_i    (clk_i),
        .w_v_i    (wr_fire),
        .w_addr_i (mem_addr),
        .w_data_i (dma_data_i),
        .r_addr_i (mem_addr),
        .r_data_o (dma_data_o)
    );

endmodule

// File: tb/tb_bp_me_cache_dma_responder.sv
// Scoreboarded random bench for the DMA responder.
// Reference model is a flat beat array indexed from byte addresses.
module tb_bp_me_cache_dma_responder;

    localparam int DW    = 28;
    localparam int FW    = 64;
    localparam int BEATS = 8;
    localparam int MEM   = 1024;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW:0]   pkt;
    logic          pkt_v, pkt_rdy;
    logic [FW-1:0] d_o, d_i;
    logic          d_v_o, d_rdy_i, d_v_i, d_rdy_o, busy;

    logic [DW:0]   z_pkt;
    logic          z_pkt_v, z_pkt_rdy;
    logic [FW-1:0] z_d_o, z_d_i;
    logic          z_d_v_o, z_d_rdy_i, z_d_v_i, z_d_rdy_o, z_busy;

    bp_me_cache_dma_responder #(.read_latency_p(LAT)) dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .dma_pkt_i            (pkt),
        .dma_pkt_v_i          (pkt_v),
        .dma_pkt_ready_and_o  (pkt_rdy),
        .dma_data_o           (d_o),
        .dma_data_v_o         (d_v_o),
        .dma_data_ready_and_i (d_rdy_i),
        .dma_data_i           (d_i),
        .dma_data_v_i         (d_v_i),
        .dma_data_ready_and_o (d_rdy_o),
        .busy_o               (busy)
    );

    bp_me_cache_dma_responder #(.read_latency_p(0)) dut_zlat (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .dma_pkt_i            (z_pkt),
        .dma_pkt_v_i          (z_pkt_v),
        .dma_pkt_ready_and_o  (z_pkt_rdy),
        .dma_data_o           (z_d_o),
        .dma_data_v_o         (z_d_v_o),
        .dma_data_ready_and_i (z_d_rdy_i),
        .dma_data_i           (z_d_i),
        .dma_data_v_i         (z_d_v_i),
        .dma_data_ready_and_o (z_d_rdy_o),
        .busy_o               (z_busy)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [63:0] model [MEM];

    // Block-aligned beat index, wrapped to the array depth.
    function automatic int midx(input logic [27:0] a, input int beat);
        int blk;
        blk = int'(a >> 3) & ~(BEATS - 1);
        return (blk | beat) % MEM;
    endfunction

    logic [63:0] exp_q[$];
    int          seen = 0;
    logic        have_prev = 1'b0;
    logic        prev_acc = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n && d_v_o) begin
            if (have_prev && !prev_acc) chk("stall_stable", d_o, prev_data);
            if (d_rdy_i) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("read_beat", d_o, exp_q.pop_front());
                seen++;
            end
            prev_data = d_o;
            prev_acc  = d_rdy_i;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    task automatic send_pkt(input bit w, input logic [27:0] a);
        int n;
        n = 0;
        pkt   = {w, a};
        pkt_v = 1'b1;
        forever begin
            @(negedge clk);
            if (pkt_rdy) break;
            n++;
            if (n > 50) begin
                chk("pkt_ready_timeout", 64'(pkt_rdy), 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        pkt_v = 1'b0;
    endtask

    task automatic write_block(input logic [27:0] a, input logic [63:0] base,
                               input bit rand_v, input int nbeats,
                               output int rdy_cycles);
        int b, cyc;
        b = 0;
        cyc = 0;
        rdy_cycles = 0;
        send_pkt(1'b1, a);
        while (b < nbeats && cyc < 200) begin
            d_v_i = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
            d_i   = base + 64'(b);
            @(negedge clk);
            if (d_rdy_o) rdy_cycles++;
            if (d_rdy_o && d_v_i) begin
                model[midx(a, b)] = d_i;
                b++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        d_v_i = 1'b0;
        chk("write_beats", 64'(b), 64'(nbeats));
    endtask

    task automatic read_block(input logic [27:0] a, input int mode,
                              input int stop_after, output int lat);
        int target, k;
        for (int b = 0; b < BEATS; b++) exp_q.push_back(model[midx(a, b)]);
        target  = seen + stop_after;
        d_rdy_i = 1'b0;
        send_pkt(1'b0, a);
        lat = 0;
        forever begin
            @(negedge clk);
            if (d_v_o) break;
            lat++;
            if (lat > 50) begin
                chk("read_valid_timeout", 64'(d_v_o), 64'd1);
                break;
            end
        end
        k = 0;
        while (seen < target && k < 300) begin
            @(posedge clk); #1;
            if (seen >= target) break;
            case (mode)
                0:       d_rdy_i = 1'b1;
                1:       d_rdy_i = (k % 3 == 0);
                default: d_rdy_i = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
        d_rdy_i = 1'b0;
        chk("read_beats", 64'(seen), 64'(target));
    endtask

    task automatic after_read();
        @(negedge clk);
        chk("post_read_pkt_ready", 64'(pkt_rdy), 64'd1);
        chk("post_read_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [27:0] wlist[$];
    initial begin
        int rc, lat;
        logic [27:0] wa, ra;
        pkt = '0; pkt_v = 0; d_rdy_i = 0; d_i = '0; d_v_i = 0;
        z_pkt = '0; z_pkt_v = 0; z_d_rdy_i = 0; z_d_i = '0; z_d_v_i = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pkt_ready", 64'(pkt_rdy), 64'd1);
        chk("rst_data_v", 64'(d_v_o), 64'd0);
        chk("rst_data_ready", 64'(d_rdy_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        write_block(28'h40, 64'h1000, 1'b0, BEATS, rc);
        chk("wr_ready_cycles", 64'(rc), 64'd8);
        @(negedge clk);
        chk("post_write_pkt_ready", 64'(pkt_rdy), 64'd1);
        @(posedge clk); #1;

        read_block(28'h47, 0, BEATS, lat);
        chk("read_latency", 64'(lat), 64'(LAT));
        after_read();
        @(posedge clk); #1;

        read_block(28'h47, 1, BEATS, lat);
        after_read();
        @(posedge clk); #1;

        write_block(28'h2040, 64'hA0, 1'b0, BEATS, rc);
        read_block(28'h40, 0, BEATS, lat);
        after_read();
        chk("alias_beat0", model[midx(28'h40, 0)], 64'hA0);
        @(posedge clk); #1;

        z_pkt = {1'b1, 28'h80};
        z_pkt_v = 1'b1;
        @(negedge clk);
        chk("zlat_pkt_ready", 64'(z_pkt_rdy), 64'd1);
        @(posedge clk); #1;
        z_pkt_v = 1'b0;
        z_d_v_i = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            z_d_i = 64'hC0 + 64'(b);
            @(posedge clk); #1;
        end
        z_d_v_i = 1'b0;
        z_pkt = {1'b0, 28'h80};
        z_pkt_v = 1'b1;
        @(negedge clk);
        chk("zlat_rd_pkt_ready", 64'(z_pkt_rdy), 64'd1);
        @(posedge clk); #1;
        z_pkt_v = 1'b0;
        z_d_rdy_i = 1'b1;
        @(negedge clk);
        chk("zlat_first_valid", 64'(z_d_v_o), 64'd1);
        chk("zlat_beat", z_d_o, 64'hC0);
        for (int b = 1; b < BEATS; b++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("zlat_beat", z_d_o, 64'hC0 + 64'(b));
        end
        @(posedge clk); #1;
        z_d_rdy_i = 1'b0;
        @(negedge clk);
        chk("zlat_done", 64'(z_d_v_o), 64'd0);
        @(posedge clk); #1;

        read_block(28'h40, 2, 3, lat);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_data_v", 64'(d_v_o), 64'd0);
        chk("midop_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        read_block(28'h40, 0, BEATS, lat);
        after_read();
        @(posedge clk); #1;

        write_block(28'h100, 64'h7700, 1'b0, BEATS, rc);
        write_block(28'h100, 64'h5500, 1'b1, 3, rc);
        rst_n = 1'b0;
        #1;
        chk("partial_wr_rst_ready", 64'(d_rdy_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        read_block(28'h100, 2, BEATS, lat);
        after_read();
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            wa = 28'($urandom);
            write_block(wa, {$urandom, $urandom}, 1'b1, BEATS, rc);
            wlist.push_back(wa);
            ra = wlist[$urandom_range(0, wlist.size() - 1)];
            ra = (ra & ~28'h3F) | 28'($urandom_range(0, 63));
            ra = ra + 28'($urandom_range(0, 7)) * 28'h2000;
            read_block(ra, 2, BEATS, lat);
            chk("rand_read_latency", 64'(lat), 64'(LAT));
            after_read();
            @(posedge clk); #1;
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bp_me_cache_dma_responder.md
Name: bp_me_cache_dma_responder

Overview:
- Memory-side endpoint of the bsg_cache DMA interface that each L2 bank drives toward DRAM.
- Accepts one DMA packet at a time. A read packet returns one block of fill beats; a write packet absorbs one block of fill beats into an internal backing array.
- Serves as the DRAM stand-in and protocol checker behind bp_me_cache_slice in unit benches and the single-bank testbench.

Parameters:
- daddr_width_p, 28, DMA byte-address width.
- fill_width_p, 64, DMA data beat width in bits.
- data_width_p, 64, cache word width in bits.
- block_size_in_words_p, 8, cache block size in words.
- mem_els_p, 1024, backing array depth in fill_width_p beats; power of two.
- read_latency_p, 4, cycles from read-packet acceptance to the first valid beat; 0 is legal.
- beats_lp (localparam) = block_size_in_words_p*data_width_p/fill_width_p; must be a power of two ≥ 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- dma_pkt_i  in  daddr_width_p+1  bsg_cache_dma_pkt_s {write_not_read, addr}.
- dma_pkt_v_i  in  1  packet valid.
- dma_pkt_ready_and_o  out  1  packet ready; transfer when v & ready.
- dma_data_o  out  fill_width_p  read fill beat.
- dma_data_v_o  out  1  read beat valid.
- dma_data_ready_and_i  in  1  read beat ready.
- dma_data_i  in  fill_width_p  write beat.
- dma_data_v_i  in  1  write beat valid.
- dma_data_ready_and_o  out  1  write beat ready.
- busy_o  out  1  high whenever state != e_ready.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - State goes to e_ready; beat counter and latency counter clear to 0.
  - dma_data_v_o, dma_data_ready_and_o and busy_o are 0. dma_pkt_ready_and_o is 1 in e_ready. dma_data_o is don't-care.
  - Backing array is not cleared.
- Address handling:
  - Block base index = addr[daddr_width_p-1 : lg(fill_width_p/8)].
  - The low lg(beats_lp) bits of the index are replaced by the beat counter. Sub-block offset bits of addr are therefore ignored.
  - Final index is truncated to lg(mem_els_p) bits, so addresses alias modulo mem_els_p*fill_width_p/8 bytes.
- e_ready:
  - dma_pkt_ready_and_o = 1; all other handshake outputs are 0.
  - On packet acceptance, latch the index and clear the beat counter.
  - Write packet → e_write.
  - Read packet → e_read_wait if read_latency_p > 0, otherwise e_read.
  - Write beats presented in e_ready are not accepted.
- e_read_wait:
  - Latency counter increments each cycle.
  - When it reaches read_latency_p-1 → e_read. The first valid beat therefore appears exactly read_latency_p cycles after the acceptance edge.
- e_read:
  - dma_data_v_o = 1; dma_data_o = mem[index] (combinational array read, stable while not accepted).
  - On dma_data_v_o & dma_data_ready_and_i, the beat counter increments.
  - Acceptance of beat beats_lp-1 → e_ready. dma_pkt_ready_and_o is high the next cycle; there is no bubble beyond that.
- e_write:
  - dma_data_ready_and_o = 1.
  - On dma_data_v_i, mem[index] <= dma_data_i and the beat counter increments.
  - Acceptance of the last beat → e_ready.
- Ordering:
  - Packets are processed strictly one at a time.
  - A read issued after a write completes returns the written data.
  - Same-cycle packet and data valid in e_ready: only the packet is accepted.
- Reset mid-operation:
  - Aborts immediately with no further beats.
  - A partially completed write leaves the already-written beats in the array.
  - The next packet is serviced in full.
- Counter widths: beat counter is lg(beats_lp) bits, minimum 1 bit. Latency counter is lg(read_latency_p+1) bits.

Decomposition:
- bp_me_pkg gets bp_me_dma_resp_state_e {e_ready, e_read_wait, e_read, e_write}.
- Packet struct: reuse bsg_cache_dma_pkt_s from bsg_cache_pkg.
- Sub-module bp_me_dma_mem_array: parameterized width and els, one write port, one combinational read port, no reset.
- FSM and counters live in the top module.

Test Plan (default parameters, beats_lp = 8):
1. Reset: hold reset_n_i low 3 cycles, release → dma_pkt_ready_and_o=1, dma_data_v_o=0, dma_data_ready_and_o=0, busy_o=0.
2. Write addr 0x40 with beats 0x1000..0x1007, dma_data_v_i held high → dma_data_ready_and_o high exactly 8 cycles; dma_pkt_ready_and_o=1 the cycle after the last beat.
3. Read addr 0x47 (offset ignored) → dma_data_v_o rises exactly 4 cycles after acceptance; returns 0x1000..0x1007 in order.
4. Same read with dma_data_ready_and_i toggling 1,0,0,1,… → dma_data_o stable while stalled; exactly 8 beats, no duplicates or drops.
5. Aliasing: write addr 0x2040 with 0xA0..0xA7, then read 0x40 → returns 0xA0..0xA7. Set read_latency_p=0 → first beat valid the cycle after acceptance.
6. Reset mid-operation: assert reset_n_i after 3 of 8 read beats → dma_data_v_o=0 immediately. A subsequent read addr 0x40 returns all 8 beats.
